// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader.
//   - DefaultWidth: default number of data bits per frame.
//   - state_e: FSM state encoding (StParity is used only when
//     SERIAL_WORD_LOADER_PARITY_EN is defined).
//   - cnt_width(): width of a counter that must hold 0..width inclusive.
package serial_word_loader_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_loader_sipo_shift_reg.sv
// Serial-in / parallel-out shift register used by serial_word_loader.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   start      - clear the register and load sin as the first bit of a frame
//   shift      - shift sin in (ignored when start is high)
//   sin        - serial data bit
//   word       - registered contents
//   word_next  - value the register takes on the next edge; lets the caller
//                capture a completed word on the same edge as its last bit
// MSB_FIRST=1 shifts left so the first bit ends in word[WIDTH-1];
// MSB_FIRST=0 shifts right so the first bit ends in word[0].
module sipo_shift_reg
    import serial_word_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] word_next
);

    logic [WIDTH-1:0] first_val;
    logic [WIDTH-1:0] shift_val;

    generate
        if (WIDTH == 1) begin : g_single
            assign first_val = sin;
            assign shift_val = sin;
        end else if (MSB_FIRST) begin : g_msb
            assign first_val = {{(WIDTH-1){1'b0}}, sin};
            assign shift_val = {word[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign first_val = {sin, {(WIDTH-1){1'b0}}};
            assign shift_val = {sin, word[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        word_next = word;
        if (start) begin
            word_next = first_val;
        end else if (shift) begin
            word_next = shift_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else begin
            word <= word_next;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// Deserialises a framed serial bit stream into WIDTH-bit words for the
// popcount stage.
// Ports:
//   clk, rst   - clock (rising edge) and asynchronous active-high reset
//   sin        - serial data bit, sampled only when sin_valid is high
//   sin_valid  - qualifies sin and sof
//   sof        - marks the current bit as data bit 0 (restarts any frame)
//   a          - assembled word, held until the next load
//   load       - one-cycle strobe, a valid in the same cycle
//   busy       - high while a frame is partially received
//   err        - one-cycle parity-error strobe (0 without parity)
// Optional feature macro: SERIAL_WORD_LOADER_PARITY_EN adds one even-parity
// bit after the data bits; an odd frame raises err instead of load.
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] a,
    output logic             load,
    output logic             busy,
    output logic             err
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_d;
    logic             load_d;
    logic [WIDTH-1:0] a_d;
    logic             start;
    logic             sr_shift;
    logic             data_done;
    logic [WIDTH-1:0] sr_word;
    logic [WIDTH-1:0] sr_word_next;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    logic             err_d;
`endif

    // sof restarts a frame from any state.
    assign start = sin_valid & sof;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift     (sr_shift),
        .sin       (sin),
        .word      (sr_word),
        .word_next (sr_word_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = 1'b0;
        a_d       = a;
        sr_shift  = 1'b0;
        data_done = 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        err_d     = 1'b0;
`endif

        if (start) begin
            state_d = StShift;
            cnt_d   = CntW'(1);
            // A single-bit frame is complete as soon as bit 0 is captured.
            data_done = (WIDTH == 1);
        end else if (sin_valid) begin
            unique case (state_q)
                StShift: begin
                    sr_shift = 1'b1;
                    if (cnt_q == LastIdx) begin
                        data_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                StParity: begin
                    // Data bits are already in sr_word; sin is the parity bit.
                    if (^{sr_word, sin}) begin
                        err_d = 1'b1;
                    end else begin
                        load_d = 1'b1;
                        a_d    = sr_word;
                    end
                    state_d = StIdle;
                    cnt_d   = '0;
                end
`endif
                default: ; // bits outside a frame are ignored
            endcase
        end

        if (data_done) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            state_d = StParity;
            cnt_d   = CntW'(WIDTH);
`else
            // Capture word_next so a updates on the edge that takes the last bit.
            state_d = StIdle;
            cnt_d   = '0;
            load_d  = 1'b1;
            a_d     = sr_word_next;
`endif
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy    <= 1'b0;
            load    <= 1'b0;
            a       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            load    <= load_d;
            a       <= a_d;
        end
    end

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
